// File: rtl/filter_seq_ctrl.sv
// Sequencer for a trapezoidal-style pulse filter: loads k/l/M, clears and settles the
// filter, then detects pulses above threshold and reports each pulse's peak and timestamp.
module filter_seq_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int PIPE_LAT         = 5,
  parameter int TS_W             = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_valid_i,
  output logic                               cfg_ready_o,
  input  logic [7:0]                         cfg_k_i,
  input  logic [7:0]                         cfg_l_i,
  input  logic [7:0]                         cfg_m_i,
  output logic                               cfg_err_o,
  output logic [7:0]                         filt_k_o,
  output logic [7:0]                         filt_l_o,
  output logic [7:0]                         filt_m_o,
  output logic                               filt_clr_o,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_data_i,
  input  logic signed [SIZE_FILTER_DATA-1:0] thr_i,
  output logic                               pk_valid_o,
  output logic signed [SIZE_FILTER_DATA-1:0] pk_amp_o,
  output logic [TS_W-1:0]                    pk_time_o,
  output logic                               busy_o
);

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, ARMED, PEAK} state_e;

  state_e                             state_q;
  logic [7:0]                         filt_k_q, filt_l_q, filt_m_q;
  logic                               filt_clr_q, cfg_err_q, pk_valid_q;
  logic signed [SIZE_FILTER_DATA-1:0] pk_amp_q, max_q;
  logic [TS_W-1:0]                    pk_time_q, max_ts_q, ts_q, ts_d;
  logic [9:0]                         settle_cnt_q, settle_cnt_d, settle_last;
  logic                               cfg_hs, cfg_bad, above_thr;

  assign cfg_ready_o  = reset && (state_q == IDLE || state_q == ARMED);
  assign busy_o       = (state_q != ARMED);
  assign cfg_hs       = cfg_valid_i && cfg_ready_o;
  assign cfg_bad      = (cfg_k_i == 8'd0) || (cfg_l_i < cfg_k_i);
  assign above_thr    = (filt_data_i > thr_i);
  assign ts_d         = ts_q + TS_W'(1);
  assign settle_cnt_d = settle_cnt_q + 10'd1;
  // Counter runs 0..k+l+PIPE_LAT-1; max 514 fits in 10 bits.
  assign settle_last  = {2'b00, filt_k_q} + {2'b00, filt_l_q} + 10'(PIPE_LAT - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      filt_k_q     <= '0;
      filt_l_q     <= '0;
      filt_m_q     <= '0;
      filt_clr_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      pk_valid_q   <= 1'b0;
      pk_amp_q     <= '0;
      pk_time_q    <= '0;
      max_q        <= '0;
      max_ts_q     <= '0;
      ts_q         <= '0;
      settle_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      filt_clr_q <= 1'b0;
      pk_valid_q <= 1'b0;
      case (state_q)
        IDLE, ARMED: begin
          // A handshake wins over a same-cycle pulse start; that sample is dropped.
          if (cfg_hs) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              filt_k_q   <= cfg_k_i;
              filt_l_q   <= cfg_l_i;
              filt_m_q   <= cfg_m_i;
              cfg_err_q  <= 1'b0;
              filt_clr_q <= 1'b1;
              state_q    <= CLEAR;
            end
          end else if (state_q == ARMED && above_thr) begin
            max_q    <= filt_data_i;
            max_ts_q <= ts_q;
            state_q  <= PEAK;
          end
        end
        CLEAR: begin
          settle_cnt_q <= '0;
          state_q      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_q == settle_last) state_q <= ARMED;
          else                             settle_cnt_q <= settle_cnt_d;
        end
        PEAK: begin
          if (!above_thr) begin
            pk_valid_q <= 1'b1;
            pk_amp_q   <= max_q;
            pk_time_q  <= max_ts_q;
            state_q    <= ARMED;
          end else if (filt_data_i > max_q) begin
            max_q    <= filt_data_i;
            max_ts_q <= ts_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign filt_k_o   = filt_k_q;
  assign filt_l_o   = filt_l_q;
  assign filt_m_o   = filt_m_q;
  assign filt_clr_o = filt_clr_q;
  assign cfg_err_o  = cfg_err_q;
  assign pk_valid_o = pk_valid_q;
  assign pk_amp_o   = pk_amp_q;
  assign pk_time_o  = pk_time_q;

endmodule

// File: doc/filter_seq_ctrl.md
FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

Interface
REQ-001 SHALL have parameter SIZE_FILTER_DATA, default 16, filter output/threshold/peak width.
REQ-002 SHALL have parameter PIPE_LAT, default 5, filter pipeline latency in clk cycles added to the settle time.
REQ-003 SHALL have parameter TS_W, default 16, timestamp counter width.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cfg_valid  in  1  configuration request.
REQ-007 cfg_ready  out  1  configuration accepted when cfg_valid and cfg_ready are both high on a rising edge.
REQ-008 cfg_k, cfg_l, cfg_m  in  8 each  requested filter k, l, M (unsigned).
REQ-009 cfg_err  out  1  sticky flag: last handshaked configuration was rejected.
REQ-010 filt_k, filt_l, filt_m  out  8 each  registered parameters driving the filter.
REQ-011 filt_clr  out  1  active-high one-cycle pulse that zeroes the filter delay line and accumulators.
REQ-012 filt_data  in  SIZE_FILTER_DATA  signed filter output sample, one per cycle.
REQ-013 thr  in  SIZE_FILTER_DATA  signed pulse-detection threshold, sampled every cycle.
REQ-014 pk_valid  out  1  one-cycle strobe, peak result valid.
REQ-015 pk_amp  out  SIZE_FILTER_DATA  signed peak amplitude.
REQ-016 pk_time  out  TS_W  timestamp of the peak sample.
REQ-017 busy  out  1  high in every state except ARMED.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, SETTLE, ARMED, PEAK.
REQ-019 cfg_ready SHALL be high only in IDLE and ARMED; a handshake in PEAK, CLEAR or SETTLE SHALL be impossible.
REQ-020 A handshake SHALL be rejected if cfg_k==0 or cfg_l<cfg_k: cfg_err set to 1 next cycle, filt_* unchanged, state unchanged.
REQ-021 An accepted handshake at edge t SHALL load filt_k/l/m, clear cfg_err and enter CLEAR, all visible after edge t.
REQ-022 CLEAR SHALL last exactly one cycle with filt_clr=1, then enter SETTLE; filt_clr SHALL be 0 in every other state.
REQ-023 SETTLE SHALL last exactly filt_k+filt_l+PIPE_LAT cycles, using a 10-bit counter with no overflow, then enter ARMED.
REQ-024 filt_data SHALL be ignored in IDLE, CLEAR and SETTLE.
REQ-025 In ARMED, a sample with filt_data > thr (signed) SHALL enter PEAK and load that sample and its timestamp as the running maximum.
REQ-026 In PEAK, a sample strictly greater than the running maximum SHALL replace it; ties SHALL keep the earlier sample.
REQ-027 In PEAK, a sample with filt_data <= thr SHALL end the pulse; that sample is not a candidate; return to ARMED.
REQ-028 At pulse end, the cycle after the terminating sample SHALL drive pk_valid=1 for exactly one cycle, with pk_amp and pk_time held until the next pk_valid.
REQ-029 The timestamp SHALL be a free-running TS_W-bit counter, cleared to 0 by reset, incremented every cycle, wrapping to 0 after all-ones.
REQ-030 A new pulse SHALL be detectable on the sample immediately after a terminating sample (back-to-back pulses).
REQ-031 A cfg handshake in ARMED SHALL take priority over a same-cycle above-threshold sample; the sample is discarded.

Reset
REQ-032 While reset==0 at an edge: state=IDLE, filt_k=filt_l=filt_m=0, filt_clr=0, cfg_err=0, pk_valid=0, pk_amp=0, pk_time=0, timestamp=0, settle counter=0, cfg_ready=0 during reset.
REQ-033 Reset asserted mid-SETTLE or mid-PEAK SHALL abort with no pk_valid; after release, state SHALL be IDLE awaiting configuration.

Verification
REQ-034 Reset release, cfg k=4 l=8 m=3 at edge t -> filt_clr high for cycle t+1 only; SETTLE 17 cycles (PIPE_LAT=5); busy low and cfg_ready high from t+19.
REQ-035 cfg k=0 or k=6 l=4 -> cfg_err=1, filt_* unchanged, state unchanged; subsequent valid cfg -> cfg_err=0.
REQ-036 ARMED, thr=100, samples 50,120,300,300,200,90 -> one pk_valid on the cycle after 90; pk_amp=300; pk_time=timestamp of the first 300.
REQ-037 Samples 150,80,150,80 with thr=100 -> two pk_valid strobes, each with pk_amp=150.
REQ-038 cfg_valid held high through a pulse -> cfg_ready low in PEAK; accepted on the first ARMED cycle after pulse end; pk_valid still issued.
REQ-039 Reset pulse during PEAK -> no pk_valid, all outputs zero, timestamp restarts at 0.
